// File: rtl/l1_tagm.sv
// L1 tag/valid array manager: one dual-port SRAM per way, a post-reset clean pass,
// and a one-cycle lookup pipeline with same-edge update bypass into the analyze stage.

module sram_dp #(
  parameter int W  = 21,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          i_a_en,
  input  logic [AW-1:0] i_a_addr,
  output logic [W-1:0]  o_a_data,
  input  logic          i_b_en,
  input  logic [AW-1:0] i_b_addr,
  input  logic [W-1:0]  i_b_data
);
  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_a_data;

  // Port A read and port B write share the edge, so a colliding read returns old data.
  always_ff @(posedge clk) begin
    if (i_a_en) r_a_data <= r_mem[i_a_addr];
    if (i_b_en) r_mem[i_b_addr] <= i_b_data;
  end

  assign o_a_data = r_a_data;
endmodule

// Handshake: a lookup (i_req) or update (i_upd_en) is accepted on any edge where
// o_ready=1; there is no back-pressure once ready, and both are ignored while cleaning.
module l1_tagm #(
  parameter int WAY_NUM   = 4,
  parameter int IDX_WIDTH = 7,
  parameter int TAG_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [IDX_WIDTH-1:0] i_idx,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_ready,
  output logic [WAY_NUM-1:0]   o_ld_val_vect,
  output logic [WAY_NUM-1:0]   o_tag_cmp_vect,
  input  logic                 i_upd_en,
  input  logic [IDX_WIDTH-1:0] i_upd_idx,
  input  logic [WAY_NUM-1:0]   i_upd_way_vect,
  input  logic [TAG_WIDTH-1:0] i_upd_tag,
  input  logic                 i_upd_val,
  output logic                 o_dbg_state
);
  localparam int DW = TAG_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {S_CLEAN = 1'b0, S_READY = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_WIDTH-1:0]   r_clean_addr;
  logic                   w_ready;
  logic                   w_rd_en;
  logic [WAY_NUM-1:0]     w_wr_en;
  logic [IDX_WIDTH-1:0]   w_wr_addr;
  logic [DW-1:0]          w_wr_data;
  logic [DW-1:0]          w_rd_data [WAY_NUM];
  logic                   r_req_r;
  logic [TAG_WIDTH-1:0]   r_tag_r;
  logic [WAY_NUM-1:0]     r_byp_mask;
  logic                   r_byp_val;
  logic [TAG_WIDTH-1:0]   r_byp_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_CLEAN;
      r_clean_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAN) r_clean_addr <= r_clean_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAN && r_clean_addr == LAST_ADDR) w_state_nxt = S_READY;
  end

  assign w_ready     = (r_state == S_READY);
  assign o_ready     = w_ready;
  assign o_dbg_state = logic'(r_state);
  assign w_rd_en     = i_req & w_ready;

  // The clean pass owns port B while cleaning; updates own it afterwards.
  always_comb begin
    w_wr_en   = '0;
    w_wr_addr = r_clean_addr;
    w_wr_data = '0;
    if (!w_ready) begin
      w_wr_en = '1;
    end else if (i_upd_en) begin
      w_wr_en   = i_upd_way_vect;
      w_wr_addr = i_upd_idx;
      w_wr_data = {i_upd_val, i_upd_tag};
    end
  end

  for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
    sram_dp #(.W(DW), .AW(IDX_WIDTH)) u_sram (
      .clk      (clk),
      .i_a_en   (w_rd_en),
      .i_a_addr (i_idx),
      .o_a_data (w_rd_data[g]),
      .i_b_en   (w_wr_en[g]),
      .i_b_addr (w_wr_addr),
      .i_b_data (w_wr_data)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_r    <= 1'b0;
      r_tag_r    <= '0;
      r_byp_mask <= '0;
      r_byp_val  <= 1'b0;
      r_byp_tag  <= '0;
    end else begin
      r_req_r <= w_rd_en;
      if (w_rd_en) r_tag_r <= i_tag;
      // SRAM returns pre-write data on a same-edge collision, so remember the update.
      if (w_rd_en && i_upd_en && i_upd_idx == i_idx) begin
        r_byp_mask <= i_upd_way_vect;
        r_byp_val  <= i_upd_val;
        r_byp_tag  <= i_upd_tag;
      end else begin
        r_byp_mask <= '0;
      end
    end
  end

  always_comb begin
    o_ld_val_vect  = '0;
    o_tag_cmp_vect = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (r_req_r) begin
        if (r_byp_mask[w]) begin
          o_ld_val_vect[w]  = r_byp_val;
          o_tag_cmp_vect[w] = (r_byp_tag == r_tag_r);
        end else begin
          o_ld_val_vect[w]  = w_rd_data[w][TAG_WIDTH];
          o_tag_cmp_vect[w] = (w_rd_data[w][TAG_WIDTH-1:0] == r_tag_r);
        end
      end
    end
  end
endmodule

// File: tb/tb_l1_tagm.sv
// Bench for l1_tagm: directed vector table plus random traffic against an array model
// of the tag store; clean timing and asynchronous reset are checked every cycle.

module tb_l1_tagm;
  localparam int WAYS = 4;
  localparam int IW   = 7;
  localparam int TW   = 20;
  localparam int SETS = 2**IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          ready;
  logic [WAYS-1:0] ld_val_vect;
  logic [WAYS-1:0] tag_cmp_vect;
  logic          upd_en;
  logic [IW-1:0] upd_idx;
  logic [WAYS-1:0] upd_way_vect;
  logic [TW-1:0] upd_tag;
  logic          upd_val;
  logic          dbg_state;

  always #5 clk = ~clk;

  l1_tagm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (req),
    .i_idx          (idx),
    .i_tag          (tag),
    .o_ready        (ready),
    .o_ld_val_vect  (ld_val_vect),
    .o_tag_cmp_vect (tag_cmp_vect),
    .i_upd_en       (upd_en),
    .i_upd_idx      (upd_idx),
    .i_upd_way_vect (upd_way_vect),
    .i_upd_tag      (upd_tag),
    .i_upd_val      (upd_val),
    .o_dbg_state    (dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;

  // reference model: plain arrays of the stored tag store plus a clean-pass edge counter
  logic          m_val [WAYS][SETS];
  logic [TW-1:0] m_tag [WAYS][SETS];
  logic          m_ready;
  int            m_cnt;
  logic [WAYS-1:0] m_exp_ld;
  logic [WAYS-1:0] m_exp_cmp;

  typedef struct {
    logic          req;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          ue;
    logic [IW-1:0] uidx;
    logic [WAYS-1:0] uway;
    logic [TW-1:0] utag;
    logic          uval;
    logic [WAYS-1:0] eld;
    logic [WAYS-1:0] ecmp;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic r, int i, int t, logic ue, int ui, logic [WAYS-1:0] uw,
                              int ut, logic uv, logic [WAYS-1:0] eld, logic [WAYS-1:0] ecmp);
    vec_t v;
    v.req = r;  v.idx = IW'(i);   v.tag = TW'(t);
    v.ue = ue;  v.uidx = IW'(ui); v.uway = uw; v.utag = TW'(ut); v.uval = uv;
    v.eld = eld; v.ecmp = ecmp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    req = v.req; idx = v.idx; tag = v.tag;
    upd_en = v.ue; upd_idx = v.uidx; upd_way_vect = v.uway; upd_tag = v.utag; upd_val = v.uval;
  endtask

  task automatic drive_idle();
    drive(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000));
  endtask

  task automatic drive_rand(int idx_max);
    req          = 1'($urandom_range(0, 1));
    idx          = IW'($urandom_range(0, idx_max));
    tag          = TW'($urandom_range(0, 3));
    upd_en       = 1'($urandom_range(0, 1));
    upd_idx      = IW'($urandom_range(0, idx_max));
    upd_way_vect = WAYS'($urandom_range(0, 15));
    upd_tag      = TW'($urandom_range(0, 3));
    upd_val      = 1'($urandom_range(0, 1));
  endtask

  // Updates sampled on an edge are visible to a lookup sampled on the same edge.
  task automatic model_edge();
    logic [WAYS-1:0] el;
    logic [WAYS-1:0] ec;
    el = '0;
    ec = '0;
    if (!m_ready) begin
      for (int w = 0; w < WAYS; w++) begin
        m_val[w][m_cnt] = 1'b0;
        m_tag[w][m_cnt] = '0;
      end
      m_cnt++;
      if (m_cnt == SETS) m_ready = 1'b1;
    end else begin
      if (upd_en)
        for (int w = 0; w < WAYS; w++)
          if (upd_way_vect[w]) begin
            m_val[w][upd_idx] = upd_val;
            m_tag[w][upd_idx] = upd_tag;
          end
      if (req)
        for (int w = 0; w < WAYS; w++) begin
          el[w] = m_val[w][idx];
          ec[w] = (m_tag[w][idx] == tag);
        end
    end
    m_exp_ld  = el;
    m_exp_cmp = ec;
  endtask

  task automatic check_now(string name);
    chk({name, ".ready"}, 32'(ready), 32'(m_ready));
    chk({name, ".ld"},    32'(ld_val_vect), 32'(m_exp_ld));
    chk({name, ".cmp"},   32'(tag_cmp_vect), 32'(m_exp_cmp));
  endtask

  // Entered and left at posedge+1: inputs are already set for the coming edge.
  task automatic cycle(string name);
    @(negedge clk);
    check_now(name);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    m_ready   = 1'b0;
    m_cnt     = 0;
    m_exp_ld  = '0;
    m_exp_cmp = '0;
    #1;
    check_now("reset_async");
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset after edge 50 of the clean pass, with lookup/update noise throughout
    for (int i = 0; i < 50; i++) begin
      drive_rand(SETS - 1);
      cycle("clean_a");
    end
    do_reset();
    for (int i = 0; i < SETS; i++) begin
      drive_rand(SETS - 1);
      cycle("clean_b");
    end

    // sweep every set: clean left valid=0 and tag=0 in all ways
    for (int s = 0; s < SETS; s++) begin
      drive(mk(1, s, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000));
      cycle("sweep");
    end

    tbl[0]  = mk(1, 5, 'hABCDE, 0, 0, 4'b0000, 0,       0, 4'b0000, 4'b0000);
    tbl[1]  = mk(0, 0, 0,       0, 0, 4'b0000, 0,       0, 4'b0000, 4'b0000);
    tbl[2]  = mk(0, 0, 0,       1, 5, 4'b0100, 'hABCDE, 1, 4'b0000, 4'b0000);
    tbl[3]  = mk(0, 0, 0,       0, 0, 4'b0000, 0,       0, 4'b0000, 4'b0000);
    tbl[4]  = mk(1, 5, 'hABCDE, 0, 0, 4'b0000, 0,       0, 4'b0100, 4'b0100);
    tbl[5]  = mk(1, 5, 'hABCDF, 0, 0, 4'b0000, 0,       0, 4'b0100, 4'b0000);
    tbl[6]  = mk(1, 9, 'h12345, 1, 9, 4'b0001, 'h12345, 1, 4'b0001, 4'b0001);
    tbl[7]  = mk(1, 9, 'h12345, 1, 9, 4'b0010, 'h12345, 1, 4'b0011, 4'b0011);
    tbl[8]  = mk(0, 0, 0,       1, 5, 4'b0100, 'hABCDE, 0, 4'b0000, 4'b0000);
    tbl[9]  = mk(1, 5, 'hABCDE, 0, 0, 4'b0000, 0,       0, 4'b0000, 4'b0100);
    tbl[10] = mk(1, 9, 'h12345, 0, 0, 4'b0000, 0,       0, 4'b0011, 4'b0011);
    tbl[11] = mk(1, 0, 0,       0, 0, 4'b0000, 0,       0, 4'b0000, 4'b1111);
    tbl[12] = mk(0, 0, 0,       0, 0, 4'b0000, 0,       0, 4'b0000, 4'b0000);

    // next row's inputs are already applied when the previous row's result is sampled
    for (int r = 0; r <= 13; r++) begin
      if (r < 13) drive(tbl[r]); else drive_idle();
      @(negedge clk);
      if (r > 0) begin
        chk($sformatf("tbl%0d.ld", r - 1),  32'(ld_val_vect),  32'(tbl[r-1].eld));
        chk($sformatf("tbl%0d.cmp", r - 1), 32'(tag_cmp_vect), 32'(tbl[r-1].ecmp));
      end
      check_now("tbl_model");
      @(posedge clk);
      model_edge();
      #1;
    end

    // random traffic on a few sets so lookups and updates collide often
    for (int i = 0; i < 400; i++) begin
      drive_rand(7);
      cycle("rand");
    end

    // reset while a lookup result is being presented
    drive(mk(1, 9, 'h12345, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000));
    cycle("pre_reset");
    do_reset();
    for (int i = 0; i < SETS; i++) begin
      drive_rand(7);
      cycle("clean_c");
    end
    for (int s = 0; s < 8; s++) begin
      drive(mk(1, s, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000));
      cycle("sweep_c");
    end
    drive_idle();
    cycle("tail");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/l1_tagm.md
Name: l1_tagm

Overview:
- L1 tag/valid array manager that feeds per-way hit information to the L1 LRU manager.
- A lookup (idx, tag) in the read stage produces `ld_val_vect` and `tag_cmp_vect` in the analyze stage, one cycle later.
- The miss/refill logic sends allocate and invalidate updates back through a separate write port.
- After reset, a hardware clean pass clears every valid bit; `ready` asserts when the pass completes.

Parameters:
- WAY_NUM, 4: number of ways (matches `L1_WAY_NUM`).
- IDX_WIDTH, 7: set index width (matches `CORE_IDX_WIDTH`); SET_NUM = 2**IDX_WIDTH.
- TAG_WIDTH, 20: stored tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  lookup request, read stage
- idx  in  IDX_WIDTH  lookup set index
- tag  in  TAG_WIDTH  lookup tag, sampled with req
- ready  out  1  clean pass done; lookups and updates accepted
- ld_val_vect  out  WAY_NUM  analyze stage: valid bit per way
- tag_cmp_vect  out  WAY_NUM  analyze stage: stored tag == lookup tag, per way
- upd_en  in  1  update strobe
- upd_idx  in  IDX_WIDTH  update set index
- upd_way_vect  in  WAY_NUM  ways to write; one or more bits
- upd_tag  in  TAG_WIDTH  tag to store
- upd_val  in  1  1 = allocate (valid=1, tag=upd_tag); 0 = invalidate (valid=0, tag=upd_tag)

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clk is the clock.
- Reset values: ready=0, ld_val_vect=0, tag_cmp_vect=0, internal req_r=0, bypass flags=0, clean FSM=CLEAN, clean address=0.
- Storage: one sram_dp per way, width TAG_WIDTH+1 holding {valid, tag}, depth SET_NUM.
  - Port A is read-only.
  - Port B is write-only.
  - Read-during-write to the same address returns old data.
- Clean FSM (states CLEAN, READY):
  - In CLEAN, each cycle writes {0,0} to all ways at the clean address, then increments the address.
  - The first edge after reset release writes address 0.
  - The write to address SET_NUM-1 moves the FSM to READY on that same edge. With defaults, ready=1 after the 128th edge.
  - READY is terminal until the next reset.
  - In CLEAN, req and upd_en are ignored: no read, no write, req_r stays 0.
- Reset mid-operation (any time, including mid-clean): all state returns to reset values and the clean pass restarts from address 0.
- Lookup, latency 1:
  - req=1 at edge N reads all ways at idx and captures idx_r/tag_r/req_r.
  - In cycle N+1: ld_val_vect[w] = stored valid; tag_cmp_vect[w] = (stored tag == tag_r).
  - Both outputs are forced to 0 whenever req_r=0.
  - Back-to-back lookups are allowed every cycle.
- Update:
  - upd_en=1 with ready=1 writes {upd_val, upd_tag} to every way selected by upd_way_vect at upd_idx, on the same edge.
  - upd_way_vect=0 means no write.
- Ordering rule: analyze-stage outputs in cycle N+1 reflect every update whose upd_en was sampled at edges up to and including N.
  - An update at edge N with upd_idx==idx of the lookup at edge N must be bypassed. Register a per-way override mask plus the update's valid and tag, then replace the SRAM data of the selected ways in the analyze stage.
  - An update at edge N+1 is not reflected in the cycle-N+1 outputs.
- Simultaneous lookup and update to different idx: independent; no stall.
- Update port writes have priority over nothing else; the only writer is the clean FSM, which is mutually exclusive with updates.

Test Plan:
1. Clean timing: release reset, hold req=0 → ready=0 for edges 1..127, ready=1 after edge 128; a backdoor read of any set shows valid=0 in all ways.
2. Lookup on clean array: req idx=5 tag=0xABCDE → next cycle ld_val_vect=4'b0000, tag_cmp_vect=4'b0000; the cycle after (req=0) both outputs are 0.
3. Allocate then lookup: upd idx=5 way=4'b0100 tag=0xABCDE val=1, then req idx=5 tag=0xABCDE two cycles later → ld_val_vect=4'b0100, tag_cmp_vect=4'b0100; req with tag=0xABCDF → tag_cmp_vect=4'b0000.
4. Same-edge bypass: upd idx=9 way=4'b0001 tag=0x12345 val=1 and req idx=9 tag=0x12345 on the same edge → next cycle ld_val_vect=4'b0001, tag_cmp_vect=4'b0001. An update on the following edge to idx=9 way=4'b0010 must not appear in that cycle.
5. Invalidate: after scenario 3, upd idx=5 way=4'b0100 val=0 tag=0xABCDE → next lookup idx=5 tag=0xABCDE gives ld_val_vect=4'b0000, tag_cmp_vect=4'b0100.
6. Reset mid-clean: drop rst_n after edge 50 → ready and outputs 0 immediately; after release, ready stays 0 for another 127 edges and asserts after edge 128; upd_en and req during clean have no effect.
